// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM access arbiter.
// Block chip-select patterns are written Block0..Block3, active low.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_VID
  } grant_e;

  localparam logic [3:0] BLOCK_NONE = 4'b1111;
  localparam logic [3:0] BLOCK0_L   = 4'b0111;
  localparam logic [3:0] BLOCK1_L   = 4'b1011;
  localparam logic [3:0] BLOCK2_L   = 4'b1101;
  localparam logic [3:0] BLOCK3_L   = 4'b1110;

  localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/sram_block_select.sv
// Decodes the top two word-address bits into one-hot-low SRAM
// block selects; all blocks deselected while disabled.
module sram_block_select
  import sram_arb_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic [3:0] block_l_o
);

  always_comb begin
    block_l_o = BLOCK_NONE;
    if (en_i) begin
      unique case (sel_i)
        2'd0: block_l_o = BLOCK0_L;
        2'd1: block_l_o = BLOCK1_L;
        2'd2: block_l_o = BLOCK2_L;
        2'd3: block_l_o = BLOCK3_L;
      endcase
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the external SRAM between the 68k CPU and the video fetch
// engine, sequencing setup/access/hold strobe timing per access.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              Clock,
  input  logic              Reset_H,
  input  logic              CpuReq_H,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic              CpuRW_H,
  input  logic              CpuUDS_L,
  input  logic              CpuLDS_L,
  input  logic [DATA_W-1:0] CpuDataOut,
  output logic [DATA_W-1:0] CpuDataIn,
  output logic              CpuDtack_L,
  input  logic              VidReq_H,
  input  logic [ADDR_W-1:0] VidAddress,
  output logic [DATA_W-1:0] VidData,
  output logic              VidAck_H,
  output logic [ADDR_W-3:0] SramAddress,
  output logic [3:0]        SramBlock_L,
  output logic              SramOE_L,
  output logic              SramWE_L,
  output logic              SramUB_L,
  output logic              SramLB_L,
  output logic [DATA_W-1:0] SramDataOut,
  output logic              SramDataOE_H,
  input  logic [DATA_W-1:0] SramDataIn
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
    WAIT_CNT_W'(WAIT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  grant_e                gnt_q, gnt_d;
  grant_e                last_q, last_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  ub_q, ub_d;
  logic                  lb_q, lb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     cdata_q, cdata_d;
  logic [DATA_W-1:0]     vdata_q, vdata_d;

  logic in_setup;
  logic in_access;
  logic in_hold;
  logic in_done;
  logic active;

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= GNT_CPU;
      last_q  <= GNT_VID;
      addr_q  <= '0;
      rd_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      wdata_q <= '0;
      cdata_q <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      wdata_q <= wdata_d;
      cdata_q <= cdata_d;
      vdata_q <= vdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    wdata_d = wdata_q;
    cdata_d = cdata_q;
    vdata_d = vdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not go last wins
        if (CpuReq_H && (!VidReq_H || last_q == GNT_VID)) begin
          gnt_d   = GNT_CPU;
          addr_d  = CpuAddress;
          rd_d    = CpuRW_H;
          ub_d    = CpuUDS_L;
          lb_d    = CpuLDS_L;
          wdata_d = CpuDataOut;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end else if (VidReq_H) begin
          gnt_d   = GNT_VID;
          addr_d  = VidAddress;
          rd_d    = 1'b1;
          ub_d    = 1'b0;
          lb_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = ST_HOLD;
          if (rd_q) begin
            if (gnt_q == GNT_CPU) cdata_d = SramDataIn;
            else                  vdata_d = SramDataIn;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d = gnt_q;
        // An aborted CPU cycle leaves without ever asserting DTACK
        if (gnt_q == GNT_VID || !CpuReq_H) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_setup  = (state_q == ST_SETUP);
  assign in_access = (state_q == ST_ACCESS);
  assign in_hold   = (state_q == ST_HOLD);
  assign in_done   = (state_q == ST_DONE);
  assign active    = in_setup | in_access | in_hold;

  sram_block_select u_bsel (
    .sel_i     (addr_q[ADDR_W-1 -: 2]),
    .en_i      (active),
    .block_l_o (SramBlock_L)
  );

  assign SramAddress  = addr_q[ADDR_W-3:0];
  assign SramOE_L     = ~(rd_q & (in_setup | in_access));
  assign SramWE_L     = ~(~rd_q & in_access);
  assign SramUB_L     = active ? ub_q : 1'b1;
  assign SramLB_L     = active ? lb_q : 1'b1;
  assign SramDataOut  = wdata_q;
  assign SramDataOE_H = active & ~rd_q;

  assign CpuDataIn  = cdata_q;
  assign VidData    = vdata_q;
  assign CpuDtack_L = ~(in_done & (gnt_q == GNT_CPU) & CpuReq_H);
  assign VidAck_H   = in_done & (gnt_q == GNT_VID);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for the SRAM access arbiter with a cycle-schedule
// reference model checked every cycle on the falling clock edge.
module tb_sram_access_arbiter;

  localparam int W = 2;

  logic        Clock = 1'b0;
  logic        Reset_H = 1'b1;
  logic        CpuReq_H = 1'b0;
  logic [16:0] CpuAddress = '0;
  logic        CpuRW_H = 1'b1;
  logic        CpuUDS_L = 1'b1;
  logic        CpuLDS_L = 1'b1;
  logic [15:0] CpuDataOut = '0;
  logic [15:0] CpuDataIn;
  logic        CpuDtack_L;
  logic        VidReq_H = 1'b0;
  logic [16:0] VidAddress = '0;
  logic [15:0] VidData;
  logic        VidAck_H;
  logic [14:0] SramAddress;
  logic [3:0]  SramBlock_L;
  logic        SramOE_L;
  logic        SramWE_L;
  logic        SramUB_L;
  logic        SramLB_L;
  logic [15:0] SramDataOut;
  logic        SramDataOE_H;
  logic [15:0] SramDataIn;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  sram_access_arbiter #(
    .ADDR_W(17), .WAIT_CYCLES(W), .DATA_W(16)
  ) dut (
    .Clock(Clock), .Reset_H(Reset_H),
    .CpuReq_H(CpuReq_H), .CpuAddress(CpuAddress),
    .CpuRW_H(CpuRW_H), .CpuUDS_L(CpuUDS_L),
    .CpuLDS_L(CpuLDS_L), .CpuDataOut(CpuDataOut),
    .CpuDataIn(CpuDataIn), .CpuDtack_L(CpuDtack_L),
    .VidReq_H(VidReq_H), .VidAddress(VidAddress),
    .VidData(VidData), .VidAck_H(VidAck_H),
    .SramAddress(SramAddress), .SramBlock_L(SramBlock_L),
    .SramOE_L(SramOE_L), .SramWE_L(SramWE_L),
    .SramUB_L(SramUB_L), .SramLB_L(SramLB_L),
    .SramDataOut(SramDataOut), .SramDataOE_H(SramDataOE_H),
    .SramDataIn(SramDataIn)
  );

  function automatic logic [15:0] pat(input logic [16:0] a);
    if (a == 17'h08004) return 16'hBEEF;
    return a[15:0] ^ (a[16] ? 16'hC3C3 : 16'h5A5A);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM pin model: contents are a fixed function of the full address
  logic [1:0] pin_blk;
  always_comb begin
    pin_blk = 2'd0;
    case (SramBlock_L)
      4'b1011: pin_blk = 2'd1;
      4'b1101: pin_blk = 2'd2;
      4'b1110: pin_blk = 2'd3;
      default: pin_blk = 2'd0;
    endcase
    SramDataIn = (!SramOE_L) ? pat({pin_blk, SramAddress}) : 16'h0000;
  end

  // Reference model: one transaction at a time, phase = cycles since grant
  bit          m_busy = 0;
  bit          m_cpu = 0;
  bit          m_rd = 1;
  bit          m_last_cpu = 0;
  bit          m_ub = 1;
  bit          m_lb = 1;
  logic [16:0] m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [15:0] m_cdata = '0;
  logic [15:0] m_vdata = '0;
  int          cyc = 0;
  int          m_t0 = 0;

  always @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      m_busy     <= 0;
      m_last_cpu <= 0;
      m_addr     <= '0;
      m_wd       <= '0;
      m_cdata    <= '0;
      m_vdata    <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (m_rd && (cyc - m_t0) == W + 1) begin
          if (m_cpu) m_cdata <= pat(m_addr);
          else       m_vdata <= pat(m_addr);
        end
        if ((cyc - m_t0) >= W + 3 && (!m_cpu || !CpuReq_H)) begin
          m_busy     <= 0;
          m_last_cpu <= m_cpu;
        end
      end else if (CpuReq_H || VidReq_H) begin
        m_busy <= 1;
        m_t0   <= cyc;
        if (CpuReq_H && (!VidReq_H || !m_last_cpu)) begin
          m_cpu  <= 1;
          m_rd   <= CpuRW_H;
          m_addr <= CpuAddress;
          m_ub   <= CpuUDS_L;
          m_lb   <= CpuLDS_L;
          m_wd   <= CpuDataOut;
        end else begin
          m_cpu  <= 0;
          m_rd   <= 1;
          m_addr <= VidAddress;
          m_ub   <= 0;
          m_lb   <= 0;
        end
      end
    end
  end

  always @(negedge Clock) begin
    int k;
    bit act, rdp, wrp, done;
    logic [3:0] one;
    logic [3:0] eblk;
    k    = cyc - m_t0;
    act  = m_busy && k >= 1 && k <= W + 2;
    rdp  = m_busy && m_rd && k >= 1 && k <= W + 1;
    wrp  = m_busy && !m_rd && k >= 2 && k <= W + 1;
    done = m_busy && k >= W + 3;
    one  = 4'b1000;
    eblk = act ? ~(one >> m_addr[16:15]) : 4'b1111;
    chk("block", SramBlock_L, eblk);
    chk("addr", SramAddress, m_addr[14:0]);
    chk("oe", SramOE_L, !rdp);
    chk("we", SramWE_L, !wrp);
    chk("ub", SramUB_L, act ? m_ub : 1'b1);
    chk("lb", SramLB_L, act ? m_lb : 1'b1);
    chk("dataoe", SramDataOE_H, act && !m_rd);
    chk("dout", SramDataOut, m_wd);
    chk("dtack", CpuDtack_L, !(done && m_cpu && CpuReq_H));
    chk("vidack", VidAck_H, done && !m_cpu);
    chk("cpudata", CpuDataIn, m_cdata);
    chk("viddata", VidData, m_vdata);
    chk("onehot", $countones(~SramBlock_L) <= 1, 1);
    chk("oe_we_excl", !SramOE_L && !SramWE_L, 0);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int         cnt;
    int         hit;
    logic [5:0] mask;
    string      seq;
    bit         redo;
    logic [16:0] va;
    logic [3:0] tab [4];
    tab = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    repeat (2) @(posedge Clock);
    #1 Reset_H = 1'b0;
    chk("rst_dtack", CpuDtack_L, 1);
    chk("rst_block", SramBlock_L, 4'b1111);
    chk("rst_oe_we", {SramOE_L, SramWE_L}, 2'b11);
    chk("rst_vidack", VidAck_H, 0);
    chk("rst_cpudata", CpuDataIn, 0);
    tick();

    // CPU read
    CpuReq_H = 1; CpuAddress = 17'h08004; CpuRW_H = 1;
    CpuUDS_L = 0; CpuLDS_L = 0;
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (!SramOE_L) cnt++;
      if (c == 1) begin
        chk("rd_block", SramBlock_L, 4'b1011);
        chk("rd_addr", SramAddress, 15'h0004);
      end
      if (c == 4) chk("rd_dtack_c4", CpuDtack_L, 1);
    end
    chk("rd_oe_cycles", cnt, 3);
    chk("rd_dtack_c5", CpuDtack_L, 0);
    chk("rd_data", CpuDataIn, 16'hBEEF);
    CpuReq_H = 0;
    #1 chk("rd_dtack_rel", CpuDtack_L, 1);
    tick();

    // CPU write, upper byte only
    CpuReq_H = 1; CpuAddress = 17'h1FFFE; CpuRW_H = 0;
    CpuDataOut = 16'h1234; CpuUDS_L = 0; CpuLDS_L = 1;
    mask = '0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (!SramWE_L) mask[c] = 1'b1;
      if (c == 1) begin
        chk("wr_block", SramBlock_L, 4'b1110);
        chk("wr_lanes", {SramUB_L, SramLB_L}, 2'b01);
        chk("wr_addr", SramAddress, 15'h7FFE);
        CpuDataOut = 16'hFFFF;
      end
      if (c <= 4) chk("wr_dout", SramDataOut, 16'h1234);
    end
    chk("wr_we_cycles", mask, 6'b001100);
    chk("wr_dtack", CpuDtack_L, 0);
    CpuReq_H = 0;
    tick();

    // Round robin from reset: CPU first, then alternate
    Reset_H = 1; tick(); Reset_H = 0; tick();
    CpuReq_H = 1; CpuAddress = 17'h10010; CpuRW_H = 1;
    CpuUDS_L = 0; CpuLDS_L = 0;
    VidReq_H = 1; VidAddress = 17'h01234;
    seq = ""; redo = 0;
    for (int c = 0; c < 60 && seq.len() < 3; c++) begin
      tick();
      if (redo) begin CpuReq_H = 1; redo = 0; end
      if (!CpuDtack_L) begin
        seq = {seq, "C"};
        chk("rr_cpudata", CpuDataIn, pat(17'h10010));
        CpuReq_H = 0; redo = 1;
      end
      if (VidAck_H) begin
        seq = {seq, "V"};
        chk("rr_viddata", VidData, pat(17'h01234));
      end
    end
    CpuReq_H = 0; VidReq_H = 0;
    chk("rr_order", seq == "CVC", 1);
    tick(); tick();

    // CPU write aborted during ACCESS
    CpuReq_H = 1; CpuAddress = 17'h04000; CpuRW_H = 0;
    CpuDataOut = 16'hCAFE; CpuUDS_L = 0; CpuLDS_L = 0;
    cnt = 0; hit = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 2) CpuReq_H = 0;
      if (!SramWE_L) cnt++;
      if (!CpuDtack_L) hit++;
      if (c == 4) chk("ab_hold_block", SramBlock_L, 4'b0111);
    end
    chk("ab_we_cycles", cnt, 2);
    chk("ab_no_dtack", hit, 0);

    // Reset in the middle of a write
    CpuReq_H = 1; CpuAddress = 17'h0C000; CpuRW_H = 0;
    CpuDataOut = 16'h5555;
    tick(); tick();
    chk("rs_we_active", SramWE_L, 0);
    #2 Reset_H = 1;
    #1;
    chk("rs_strobes", {SramWE_L, SramOE_L, SramDataOE_H}, 3'b110);
    chk("rs_block", SramBlock_L, 4'b1111);
    CpuReq_H = 0;
    tick(); tick();
    Reset_H = 0;
    tick();
    CpuReq_H = 1; CpuAddress = 17'h18008; CpuRW_H = 1;
    hit = 0;
    for (int c = 1; c <= 10 && hit == 0; c++) begin
      tick();
      if (!CpuDtack_L) hit = c;
    end
    chk("rs_latency", hit, 5);
    chk("rs_data", CpuDataIn, pat(17'h18008));
    CpuReq_H = 0;
    tick();

    // Video reads across all four blocks
    for (int i = 0; i < 4; i++) begin
      va = {2'(i), 15'h0100 + 15'(i)};
      VidReq_H = 1; VidAddress = va;
      tick();
      chk("sw_block", SramBlock_L, tab[i]);
      hit = 0;
      for (int c = 2; c <= 10 && hit == 0; c++) begin
        tick();
        if (VidAck_H) begin
          hit = c;
          chk("sw_data", VidData, pat(va));
        end
      end
      VidReq_H = 0;
      chk("sw_ack_cycle", hit, 5);
      tick();
    end

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
